// File: rtl/apb_master_pkg.sv
// Shared types and constants for the APB master bridge.
package apb_master_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  localparam int          SLOT_SHIFT        = 12;
  localparam int          WINDOW_SHIFT      = 16;
  localparam logic [31:0] DEFAULT_ADDR_BASE = 32'h1000_0000;

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational decode of a CPU byte address into a slave hit and a 4 KB slot index.
module apb_addr_decoder
  import apb_master_pkg::*;
#(
  parameter int          NUM_SLAVES = 4,
  parameter logic [31:0] ADDR_BASE  = DEFAULT_ADDR_BASE
) (
  input  logic [31:0] addr,
  output logic        hit,
  output logic [3:0]  index
);

  localparam logic [4:0] NUM_SLAVES_W = 5'(NUM_SLAVES);

  logic unused_offset_bits;
  assign unused_offset_bits = ^addr[SLOT_SHIFT-1:0];

  // Window match plus slot range check
  always_comb begin
    index = addr[WINDOW_SHIFT-1:SLOT_SHIFT];
    hit   = (addr[31:WINDOW_SHIFT] == ADDR_BASE[31:WINDOW_SHIFT]) &&
            ({1'b0, index} < NUM_SLAVES_W);
  end

endmodule

// File: rtl/apb_master_bridge.sv
// APB initiator: CPU single-word load/store to APB SETUP/ACCESS transfers.
// Optional ACCESS-phase timeout is enabled with the APB_MASTER_TIMEOUT_EN macro.
module apb_master_bridge
  import apb_master_pkg::*;
#(
  parameter int          NUM_SLAVES     = 4,
  parameter logic [31:0] ADDR_BASE      = DEFAULT_ADDR_BASE,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic                       PCLK,
  input  logic                       PRESET,
  input  logic                       req,
  input  logic                       we,
  input  logic [31:0]                addr,
  input  logic [31:0]                wdata,
  output logic [31:0]                rdata,
  output logic                       done,
  output logic                       err,
  output logic                       busy,
  output logic [31:0]                PADDR,
  output logic                       PWRITE,
  output logic [31:0]                PWDATA,
  output logic                       PENABLE,
  output logic [NUM_SLAVES-1:0]      PSEL,
  input  logic [NUM_SLAVES*32-1:0]   PRDATA_ALL,
  input  logic [NUM_SLAVES-1:0]      PREADY_ALL
);

  apb_state_t              state_q, state_d;
  logic [31:0]             paddr_q, paddr_d;
  logic                    pwrite_q, pwrite_d;
  logic [31:0]             pwdata_q, pwdata_d;
  logic                    penable_q, penable_d;
  logic [NUM_SLAVES-1:0]   psel_q, psel_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    busy_q, busy_d;
  logic [3:0]              index_q, index_d;

  logic                    dec_hit;
  logic [3:0]              dec_index;
  logic [NUM_SLAVES-1:0]   dec_onehot;
  logic                    pready_sel;
  logic [31:0]             prdata_sel;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  assign cnt_inc = cnt_q + CNT_W'(1);
`else
  localparam int timeout_unused = TIMEOUT_CYCLES;
`endif

  apb_addr_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .ADDR_BASE  (ADDR_BASE)
  ) u_decoder (
    .addr  (addr),
    .hit   (dec_hit),
    .index (dec_index)
  );

  // Select the latched slave's PREADY/PRDATA and build the one-hot select for a new request
  always_comb begin
    pready_sel = 1'b0;
    prdata_sel = 32'h0000_0000;
    dec_onehot = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      pready_sel    = (index_q == i[3:0]) ? PREADY_ALL[i] : pready_sel;
      prdata_sel    = (index_q == i[3:0]) ? PRDATA_ALL[32*i +: 32] : prdata_sel;
      dec_onehot[i] = (dec_index == i[3:0]);
    end
  end

  // Next-state and next-output logic for the transfer FSM
  always_comb begin
    state_d   = state_q;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    penable_d = penable_q;
    psel_d    = psel_q;
    rdata_d   = rdata_q;
    index_d   = index_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (req && dec_hit) begin
          paddr_d   = addr;
          pwrite_d  = we;
          pwdata_d  = wdata;
          index_d   = dec_index;
          psel_d    = dec_onehot;
          penable_d = 1'b0;
          busy_d    = 1'b1;
          state_d   = SETUP;
        end else if (req) begin
          err_d     = 1'b1;
        end else begin
          state_d   = IDLE;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
        cnt_d     = '0;
`endif
      end
      ACCESS: begin
        if (pready_sel) begin
          if (!pwrite_q) begin
            rdata_d = prdata_sel;
          end else begin
            rdata_d = rdata_q;
          end
          done_d    = 1'b1;
          psel_d    = '0;
          penable_d = 1'b0;
          busy_d    = 1'b0;
          state_d   = IDLE;
`ifdef APB_MASTER_TIMEOUT_EN
        end else if (cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
          err_d     = 1'b1;
          rdata_d   = 32'h0000_0000;
          psel_d    = '0;
          penable_d = 1'b0;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end else begin
          cnt_d     = cnt_inc;
        end
`else
        end else begin
          state_d   = ACCESS;
        end
`endif
      end
      default: begin
        psel_d    = '0;
        penable_d = 1'b0;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  // State and registered outputs with synchronous reset
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= IDLE;
      paddr_q   <= 32'h0000_0000;
      pwrite_q  <= 1'b0;
      pwdata_q  <= 32'h0000_0000;
      penable_q <= 1'b0;
      psel_q    <= '0;
      rdata_q   <= 32'h0000_0000;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      index_q   <= 4'h0;
`ifdef APB_MASTER_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      penable_q <= penable_d;
      psel_q    <= psel_d;
      rdata_q   <= rdata_d;
      done_q    <= done_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      index_q   <= index_d;
`ifdef APB_MASTER_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign PADDR   = paddr_q;
  assign PWRITE  = pwrite_q;
  assign PWDATA  = pwdata_q;
  assign PENABLE = penable_q;
  assign PSEL    = psel_q;
  assign rdata   = rdata_q;
  assign done    = done_q;
  assign err     = err_q;
  assign busy    = busy_q;

endmodule
